// File: rtl/datapath_sequencer.sv
// Program sequencer feeding the regfile/ALU32 datapath: small writable instruction
// memory, two-cycle fetch/execute, jumps, HALT, sticky overflow and a step watchdog.
module datapath_sequencer #(
  parameter int PROG_DEPTH  = 16,
  parameter int PC_W        = 4,
  parameter int MAX_STEPS   = 255,
  parameter bit HALT_ON_OVF = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [15:0]     prog_data,
  input  logic            Zero,
  input  logic            Overflow,
  output logic [2:0]      ALUControl,
  output logic [1:0]      addr1,
  output logic [1:0]      addr2,
  output logic [1:0]      addr3,
  output logic            wr,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            done,
  output logic            ovf_flag,
  output logic            timeout
);

  // state   | meaning
  // S_IDLE  | after reset, waiting for start
  // S_FETCH | instr <= mem[pc]
  // S_EXEC  | decode instr, drive datapath, update pc/flags
  // S_HALT  | run finished, done=1 until start or reset
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [2:0]      OP_ALU   = 3'b000;
  localparam logic [2:0]      OP_BEQZ  = 3'b001;
  localparam logic [2:0]      OP_JMP   = 3'b010;
  localparam logic [2:0]      OP_HALT  = 3'b011;
  localparam logic [7:0]      STEP_LIM = 8'(MAX_STEPS);
  localparam logic [PC_W-1:0] LAST_PC  = PC_W'(PROG_DEPTH - 1);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        steps_q, steps_d;
  logic              z_flag_q, z_flag_d;
  logic              ovf_q, ovf_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       mem_q [PROG_DEPTH];

  logic [2:0]        op;
  logic [PC_W-1:0]   target;
  logic [PC_W-1:0]   pc_inc;
  logic [7:0]        steps_inc;
  logic              jump;
  logic              ovf_halt;
  logic              can_prog;

  assign op        = instr_q[15:13];
  assign target    = instr_q[PC_W-1:0];
  assign pc_inc    = pc_q + PC_W'(1);
  assign steps_inc = steps_q + 8'd1;
  assign can_prog  = (state_q == S_IDLE) || (state_q == S_HALT);

  // Program memory has no reset so a loaded program survives a reset.
  always_ff @(posedge clk) begin
    if (prog_we && can_prog) mem_q[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      steps_q   <= '0;
      z_flag_q  <= 1'b0;
      ovf_q     <= 1'b0;
      timeout_q <= 1'b0;
      instr_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      steps_q   <= steps_d;
      z_flag_q  <= z_flag_d;
      ovf_q     <= ovf_d;
      timeout_q <= timeout_d;
      instr_q   <= instr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    steps_d    = steps_q;
    z_flag_d   = z_flag_q;
    ovf_d      = ovf_q;
    timeout_d  = timeout_q;
    instr_d    = instr_q;
    ALUControl = 3'd0;
    addr1      = 2'd0;
    addr2      = 2'd0;
    addr3      = 2'd0;
    wr         = 1'b0;
    jump       = 1'b0;
    ovf_halt   = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d      = '0;
          steps_d   = '0;
          z_flag_d  = 1'b0;
          ovf_d     = 1'b0;
          timeout_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        instr_d = mem_q[pc_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        steps_d = steps_inc;
        case (op)
          OP_ALU: begin
            wr         = 1'b1;
            ALUControl = instr_q[12:10];
            addr3      = instr_q[9:8];
            addr1      = instr_q[7:6];
            addr2      = instr_q[5:4];
            z_flag_d   = Zero;
            if (Overflow) ovf_d = 1'b1;
            ovf_halt   = HALT_ON_OVF && Overflow;
          end
          OP_BEQZ: jump = z_flag_q;
          OP_JMP:  jump = 1'b1;
          default: ;
        endcase

        // Falling off the last word halts with pc parked there rather than wrapping.
        if (op == OP_HALT)  pc_d = pc_q;
        else if (jump)      pc_d = target;
        else if (pc_q != LAST_PC) pc_d = pc_inc;

        if (op == OP_HALT || ovf_halt) begin
          state_d = S_HALT;
        end else if (steps_inc == STEP_LIM) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else if (pc_q == LAST_PC && !jump) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pc       = pc_q;
  assign busy     = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign done     = (state_q == S_HALT);
  assign ovf_flag = ovf_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: one task per scenario, inputs driven and
// outputs sampled on the falling clock edge.
module tb_datapath_sequencer;

  logic        clk, rst, start, start4, prog_we, Zero, Overflow;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;

  logic [2:0]  ALUControl, ALUControl_4;
  logic [1:0]  addr1, addr2, addr3, addr1_4, addr2_4, addr3_4;
  logic        wr, busy, done, ovf_flag, timeout;
  logic        wr_4, busy_4, done_4, ovf_flag_4, timeout_4;
  logic [3:0]  pc, pc_4;

  int checks = 0;
  int passed = 0;

  datapath_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .Zero(Zero), .Overflow(Overflow), .ALUControl(ALUControl),
    .addr1(addr1), .addr2(addr2), .addr3(addr3), .wr(wr), .pc(pc), .busy(busy),
    .done(done), .ovf_flag(ovf_flag), .timeout(timeout)
  );

  // Short watchdog instance for the step-limit scenario.
  datapath_sequencer #(.MAX_STEPS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .Zero(Zero), .Overflow(Overflow), .ALUControl(ALUControl_4),
    .addr1(addr1_4), .addr2(addr2_4), .addr3(addr3_4), .wr(wr_4), .pc(pc_4), .busy(busy_4),
    .done(done_4), .ovf_flag(ovf_flag_4), .timeout(timeout_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    prog_addr = a;
    prog_data = d;
    prog_we   = 1'b1;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 0; start4 = 0; prog_we = 0; Zero = 0; Overflow = 0;
    prog_addr = '0; prog_data = '0;
    #12;
    checks++;
    if ({ALUControl, addr1, addr2, addr3, wr, pc, busy, done, ovf_flag, timeout} !== 19'd0)
      $display("FAIL reset_outputs: got %h want 0",
               {ALUControl, addr1, addr2, addr3, wr, pc, busy, done, ovf_flag, timeout});
    else passed++;
    checks++;
    if ({wr_4, pc_4, busy_4, done_4, timeout_4} !== 8'd0)
      $display("FAIL reset_outputs4: got %h want 0", {wr_4, pc_4, busy_4, done_4, timeout_4});
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, pc} !== 6'd0)
      $display("FAIL idle_no_start: got busy=%b done=%b pc=%0d want 0 0 0", busy, done, pc);
    else passed++;
  endtask

  // Runs the ADD/HALT program already in memory and checks every cycle of it.
  task automatic t1_run(input string tag);
    pulse_start();
    checks++;
    if ({busy, wr, pc} !== {1'b1, 1'b0, 4'd0})
      $display("FAIL %s_fetch0: got busy=%b wr=%b pc=%0d want 1 0 0", tag, busy, wr, pc);
    else passed++;
    @(negedge clk);
    checks++;
    if ({wr, ALUControl, addr1, addr2, addr3} !== {1'b1, 3'd0, 2'd1, 2'd2, 2'd0})
      $display("FAIL %s_exec_alu: got wr=%b alu=%0d a1=%0d a2=%0d a3=%0d want 1 0 1 2 0",
               tag, wr, ALUControl, addr1, addr2, addr3);
    else passed++;
    @(negedge clk);
    checks++;
    if ({wr, pc} !== {1'b0, 4'd1})
      $display("FAIL %s_fetch1: got wr=%b pc=%0d want 0 1", tag, wr, pc);
    else passed++;
    @(negedge clk);
    checks++;
    if ({wr, busy} !== 2'b01)
      $display("FAIL %s_exec_halt: got wr=%b busy=%b want 0 1", tag, wr, busy);
    else passed++;
    @(negedge clk);
    checks++;
    if ({done, busy, pc} !== {1'b1, 1'b0, 4'd1})
      $display("FAIL %s_done: got done=%b busy=%b pc=%0d want 1 0 1", tag, done, busy, pc);
    else passed++;
  endtask

  task automatic test_t1();
    load(4'd0, 16'h0060);
    load(4'd1, 16'h6000);
    t1_run("t1");
  endtask

  task automatic test_beqz();
    load(4'd0, 16'h1B60);
    load(4'd1, 16'h2005);
    load(4'd5, 16'h6000);
    load(4'd2, 16'h6000);
    Zero = 1'b1;
    pulse_start();
    checks++;
    if (pc !== 4'd0) $display("FAIL t2_pc0: got %0d want 0", pc); else passed++;
    @(negedge clk);
    checks++;
    if ({wr, ALUControl, addr3, addr1, addr2} !== {1'b1, 3'd6, 2'd3, 2'd1, 2'd2})
      $display("FAIL t2_sub: got wr=%b alu=%0d a3=%0d a1=%0d a2=%0d want 1 6 3 1 2",
               wr, ALUControl, addr3, addr1, addr2);
    else passed++;
    @(negedge clk);
    checks++;
    if (pc !== 4'd1) $display("FAIL t2_pc1: got %0d want 1", pc); else passed++;
    @(negedge clk);
    checks++;
    if (wr !== 1'b0) $display("FAIL t2_beqz_wr: got %b want 0", wr); else passed++;
    @(negedge clk);
    checks++;
    if (pc !== 4'd5) $display("FAIL t2_pc5: got %0d want 5", pc); else passed++;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({done, pc} !== {1'b1, 4'd5})
      $display("FAIL t2_done: got done=%b pc=%0d want 1 5", done, pc);
    else passed++;

    // Not taken: ALU leaves z_flag clear, BEQZ falls through to the HALT at 2.
    Zero = 1'b0;
    pulse_start();
    repeat (4) @(negedge clk);
    checks++;
    if (pc !== 4'd2) $display("FAIL t2n_pc2: got %0d want 2", pc); else passed++;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({done, pc} !== {1'b1, 4'd2})
      $display("FAIL t2n_done: got done=%b pc=%0d want 1 2", done, pc);
    else passed++;
  endtask

  task automatic test_watchdog();
    int cycles = 0;
    int busy_cnt = 0;
    load(4'd0, 16'h4000);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    while (!done_4 && cycles < 40) begin
      if (busy_4) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (done_4 !== 1'b1) $display("FAIL t3_done: got %b want 1 (after %0d cycles)", done_4, cycles);
    else passed++;
    checks++;
    if (busy_cnt !== 8) $display("FAIL t3_busy_cycles: got %0d want 8", busy_cnt); else passed++;
    checks++;
    if ({timeout_4, busy_4, pc_4} !== {1'b1, 1'b0, 4'd0})
      $display("FAIL t3_flags: got timeout=%b busy=%b pc=%0d want 1 0 0", timeout_4, busy_4, pc_4);
    else passed++;
  endtask

  task automatic test_overflow();
    load(4'd0, 16'h0060);
    load(4'd1, 16'h8000);
    Overflow = 1'b1;
    pulse_start();
    @(negedge clk);
    checks++;
    if (wr !== 1'b1) $display("FAIL t4_wr: got %b want 1", wr); else passed++;
    @(negedge clk);
    Overflow = 1'b0;
    checks++;
    if ({done, busy, ovf_flag, timeout} !== 4'b1010)
      $display("FAIL t4_halt: got done=%b busy=%b ovf=%b timeout=%b want 1 0 1 0",
               done, busy, ovf_flag, timeout);
    else passed++;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b01)
      $display("FAIL t4_no_fetch: got busy=%b done=%b want 0 1", busy, done);
    else passed++;
  endtask

  task automatic test_nop_walk();
    for (int i = 0; i < 16; i++) load(4'(i), 16'h8000);
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (pc !== 4'(i)) $display("FAIL t5_pc_walk: got %0d want %0d", pc, i); else passed++;
      @(negedge clk);
      if (i == 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if ({done, pc, timeout, ovf_flag} !== {1'b1, 4'd15, 1'b0, 1'b0})
      $display("FAIL t5_end: got done=%b pc=%0d timeout=%b ovf=%b want 1 15 0 0",
               done, pc, timeout, ovf_flag);
    else passed++;
  endtask

  task automatic test_reset_midrun();
    load(4'd0, 16'h0060);
    load(4'd1, 16'h6000);
    pulse_start();
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = 16'h6000;
    @(negedge clk);
    prog_we = 1'b0;
    checks++;
    if (wr !== 1'b1) $display("FAIL t6_exec_wr: got %b want 1", wr); else passed++;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({ALUControl, addr1, addr2, addr3, wr, pc, busy, done, ovf_flag, timeout} !== 19'd0)
      $display("FAIL t6_async_clear: got %h want 0",
               {ALUControl, addr1, addr2, addr3, wr, pc, busy, done, ovf_flag, timeout});
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00)
      $display("FAIL t6_idle: got busy=%b done=%b want 0 0", busy, done);
    else passed++;
    t1_run("t6_rerun");
  endtask

  initial begin
    test_reset();
    test_t1();
    test_beqz();
    test_watchdog();
    test_overflow();
    test_nop_walk();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
